// File: rtl/poly_mul_seq_if.sv
// Command/status and core-control bundle for poly_mul_seq.
// The slave side is the sequencer; the master side is the command source plus the polytop_RE core.
interface poly_mul_seq_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [4:0] cmd_mask;
   logic       abort;
   logic       core_rst;
   logic [1:0] core_opcode;
   logic       core_mode;
   logic       core_offset;
   logic       core_start;
   logic       core_finish;
   logic       busy;
   logic       stage_done;
   logic [2:0] stage_id;
   logic       done;
   logic [1:0] err;

   modport master (
      output cmd_valid, cmd_mask, abort, core_finish,
      input  cmd_ready, core_rst, core_opcode, core_mode, core_offset, core_start,
             busy, stage_done, stage_id, done, err
   );

   modport slave (
      input  cmd_valid, cmd_mask, abort, core_finish,
      output cmd_ready, core_rst, core_opcode, core_mode, core_offset, core_start,
             busy, stage_done, stage_id, done, err
   );
endinterface

// File: rtl/poly_mul_seq.sv
// Five-stage command sequencer for polytop_RE: NTT f, NTT g, PWM0, PWM1, INTT.
// Every output is a register computed from the next state, so nothing here is combinational to the pins.
module poly_mul_seq #(
   parameter int RST_CYC     = 2,
   parameter int GAP_CYC     = 4,
   parameter int TIMEOUT_CYC = 4096,
   parameter int TO_W        = 13
) (
   input  logic          clk,
   input  logic          rst,
   poly_mul_seq_if.slave bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PICK  = 3'd1;
   localparam logic [2:0] S_CRST  = 3'd2;
   localparam logic [2:0] S_START = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_GAP   = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   localparam logic [TO_W-1:0] RST_LAST = TO_W'(RST_CYC - 1);
   localparam logic [TO_W-1:0] GAP_LAST = TO_W'(GAP_CYC - 1);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

   logic [2:0]      state_q, state_d;
   logic [4:0]      mask_q, mask_d;
   logic [2:0]      ptr_q, ptr_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            cmd_ready_q, cmd_ready_d;
   logic            core_rst_q, core_rst_d;
   logic [1:0]      core_opcode_q, core_opcode_d;
   logic            core_mode_q, core_mode_d;
   logic            core_offset_q, core_offset_d;
   logic            core_start_q, core_start_d;
   logic            busy_q, busy_d;
   logic            stage_done_q, stage_done_d;
   logic [2:0]      stage_id_q, stage_id_d;
   logic            done_q, done_d;
   logic [1:0]      err_q, err_d;

   logic            found;
   logic [2:0]      pick_idx;

   // Stage table packed as {opcode, mode, offset}
   function automatic logic [3:0] stage_cfg(input logic [2:0] id);
      case (id)
         3'd0:    stage_cfg = 4'b00_0_0;
         3'd1:    stage_cfg = 4'b00_1_1;
         3'd2:    stage_cfg = 4'b10_0_0;
         3'd3:    stage_cfg = 4'b11_0_0;
         3'd4:    stage_cfg = 4'b01_0_0;
         default: stage_cfg = 4'b00_0_0;
      endcase
   endfunction

   // Lowest enabled stage at or above the pointer; descending scan so the lowest hit wins
   always_comb begin
      found    = 1'b0;
      pick_idx = 3'd5;
      for (int i = 4; i >= 0; i--) begin
         if (mask_q[i] && (3'(i) >= ptr_q)) begin
            found    = 1'b1;
            pick_idx = 3'(i);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      mask_d        = mask_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      core_opcode_d = core_opcode_q;
      core_mode_d   = core_mode_q;
      core_offset_d = core_offset_q;
      stage_id_d    = stage_id_q;
      err_d         = err_q;
      stage_done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               mask_d  = bus.cmd_mask;
               err_d   = 2'b00;
               ptr_d   = 3'd0;
               state_d = S_PICK;
            end
         end
         S_PICK: begin
            if (!found) begin
               state_d = S_DONE;
            end else begin
               ptr_d = pick_idx;
               {core_opcode_d, core_mode_d, core_offset_d} = stage_cfg(pick_idx);
               cnt_d   = '0;
               state_d = S_CRST;
            end
         end
         S_CRST: begin
            if (cnt_q == RST_LAST) state_d = S_START;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.core_finish) begin
               stage_done_d = 1'b1;
               stage_id_d   = ptr_q;
               ptr_d        = ptr_q + 3'd1;
               cnt_d        = '0;
               state_d      = (GAP_CYC == 0) ? S_PICK : S_GAP;
            end else if (cnt_q == TO_LAST) begin
               err_d[0] = 1'b1;
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) state_d = S_PICK;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Abort outranks finish and timeout; the interrupted stage reports nothing
      if (bus.abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
         state_d      = S_DONE;
         err_d[1]     = 1'b1;
         stage_done_d = 1'b0;
         stage_id_d   = stage_id_q;
      end
   end

   // Registered outputs follow the state being entered
   always_comb begin
      core_start_d = (state_d == S_START);
      done_d       = (state_d == S_DONE);
      busy_d       = (state_d != S_IDLE);
      cmd_ready_d  = (state_d == S_IDLE);
      core_rst_d   = core_rst_q;
      case (state_d)
         S_IDLE, S_CRST, S_DONE: core_rst_d = 1'b1;
         S_START:                core_rst_d = 1'b0;
         default:                core_rst_d = core_rst_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         mask_q        <= '0;
         ptr_q         <= '0;
         cnt_q         <= '0;
         cmd_ready_q   <= 1'b1;
         core_rst_q    <= 1'b1;
         core_opcode_q <= '0;
         core_mode_q   <= 1'b0;
         core_offset_q <= 1'b0;
         core_start_q  <= 1'b0;
         busy_q        <= 1'b0;
         stage_done_q  <= 1'b0;
         stage_id_q    <= '0;
         done_q        <= 1'b0;
         err_q         <= '0;
      end else begin
         state_q       <= state_d;
         mask_q        <= mask_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         cmd_ready_q   <= cmd_ready_d;
         core_rst_q    <= core_rst_d;
         core_opcode_q <= core_opcode_d;
         core_mode_q   <= core_mode_d;
         core_offset_q <= core_offset_d;
         core_start_q  <= core_start_d;
         busy_q        <= busy_d;
         stage_done_q  <= stage_done_d;
         stage_id_q    <= stage_id_d;
         done_q        <= done_d;
         err_q         <= err_d;
      end
   end

   assign bus.cmd_ready   = cmd_ready_q;
   assign bus.core_rst    = core_rst_q;
   assign bus.core_opcode = core_opcode_q;
   assign bus.core_mode   = core_mode_q;
   assign bus.core_offset = core_offset_q;
   assign bus.core_start  = core_start_q;
   assign bus.busy        = busy_q;
   assign bus.stage_done  = stage_done_q;
   assign bus.stage_id    = stage_id_q;
   assign bus.done        = done_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_poly_mul_seq.sv
// Directed bench for poly_mul_seq with a behavioural core model and start/stage scoreboards.
module tb_poly_mul_seq;
   localparam int L  = 20;
   localparam int TO = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   poly_mul_seq_if bus ();

   poly_mul_seq #(.RST_CYC(2), .GAP_CYC(4), .TIMEOUT_CYC(TO), .TO_W(7)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bit model_en = 1'b1;
   bit inj = 1'b0;
   int fin_cnt = 0;

   logic [3:0] exp_start[$];
   logic [2:0] exp_sid[$];
   int n_start = 0, n_sdone = 0, n_done = 0, t_start = 0, t_sdone = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Core model: finish pulses L cycles after start; optional stray finish in the START cycle
   initial forever begin
      @(negedge clk);
      bus.core_finish = 1'b0;
      if (fin_cnt > 0) begin
         fin_cnt--;
         if (fin_cnt == 0) bus.core_finish = 1'b1;
      end
      if (rst && bus.core_start) begin
         fin_cnt = model_en ? L : 0;
         if (inj) bus.core_finish = 1'b1;
      end
   end

   // Monitor: pops expected start configs and stage ids as the DUT produces them
   initial begin
      logic prev_rst;
      prev_rst = 1'b1;
      forever begin
         @(negedge clk);
         if (rst && bus.core_start) begin
            n_start++;
            t_start = cyc;
            chk("rst_before_start", 32'(prev_rst), 32'd1);
            chk("rst_in_start", 32'(bus.core_rst), 32'd0);
            if (exp_start.size() == 0)
               chk("start_unexp", 32'({bus.core_opcode, bus.core_mode, bus.core_offset}), 32'h100);
            else
               chk("start_cfg", 32'({bus.core_opcode, bus.core_mode, bus.core_offset}),
                   32'(exp_start.pop_front()));
         end
         if (rst && bus.stage_done) begin
            n_sdone++;
            t_sdone = cyc;
            if (exp_sid.size() == 0) chk("sdone_unexp", 32'(bus.stage_id), 32'h100);
            else                     chk("stage_id", 32'(bus.stage_id), 32'(exp_sid.pop_front()));
         end
         if (rst && bus.done) n_done++;
         prev_rst = bus.core_rst;
      end
   end

   task automatic send_cmd(input logic [4:0] mask, output int t_acc);
      bit got;
      got = 1'b0;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_mask  = mask;
      for (int k = 0; k < 300; k++) begin
         if (bus.cmd_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      t_acc = cyc;
      chk("accept", 32'(got), 32'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int t_done);
      bit got;
      got = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (bus.done) begin
            got = 1'b1;
            break;
         end
      end
      t_done = cyc;
      chk("done_seen", 32'(got), 32'd1);
   endtask

   task automatic wait_start(input int n, output int t_s);
      int seen;
      seen = 0;
      for (int k = 0; k < 400 && seen < n; k++) begin
         @(negedge clk);
         if (bus.core_start) seen++;
      end
      t_s = cyc;
      chk("start_seen", 32'(seen), 32'(n));
   endtask

   function automatic logic [13:0] out_vec();
      return {bus.core_rst, bus.core_opcode, bus.core_mode, bus.core_offset, bus.core_start,
              bus.busy, bus.stage_done, bus.stage_id, bus.done, bus.err};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int ta, td, ts, nd;
      bus.cmd_valid   = 1'b0;
      bus.cmd_mask    = '0;
      bus.abort       = 1'b0;
      bus.core_finish = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'(out_vec()), 32'h2000);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(bus.cmd_ready), 32'd1);

      // T1: full five-stage flow
      exp_start = '{4'b0000, 4'b0011, 4'b1000, 4'b1100, 4'b0100};
      exp_sid   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      nd = n_done;
      send_cmd(5'h1F, ta);
      chk("t1_busy", 32'(bus.busy), 32'd1);
      chk("t1_ready_busy", 32'(bus.cmd_ready), 32'd0);
      wait_done(400, td);
      chk("t1_err", 32'(bus.err), 32'd0);
      chk("t1_rst_done", 32'(bus.core_rst), 32'd1);
      repeat (3) @(negedge clk);
      chk("t1_done_cnt", 32'(n_done - nd), 32'd1);
      chk("t1_start_left", 32'(exp_start.size()), 32'd0);
      chk("t1_sid_left", 32'(exp_sid.size()), 32'd0);
      chk("t1_stage_id_hold", 32'(bus.stage_id), 32'd4);

      // T2: PWM stages only
      exp_start = '{4'b1000, 4'b1100};
      exp_sid   = '{3'd2, 3'd3};
      send_cmd(5'b01100, ta);
      wait_done(200, td);
      chk("t2_err", 32'(bus.err), 32'd0);
      repeat (2) @(negedge clk);
      chk("t2_start_left", 32'(exp_start.size()), 32'd0);
      chk("t2_sid_left", 32'(exp_sid.size()), 32'd0);

      // T3: core never finishes
      model_en  = 1'b0;
      exp_start = '{4'b0000};
      send_cmd(5'h01, ta);
      wait_start(1, ts);
      wait_done(200, td);
      chk("t3_latency", 32'(td - ts), 32'd65);
      chk("t3_err", 32'(bus.err), 32'd1);
      chk("t3_core_rst", 32'(bus.core_rst), 32'd1);
      model_en = 1'b1;
      @(negedge clk);
      chk("t3_err_sticky", 32'(bus.err), 32'd1);

      // T4: abort 5 cycles into stage-1 WAIT, then a normal command
      exp_start = '{4'b0000, 4'b0011};
      exp_sid   = '{3'd0};
      send_cmd(5'h1F, ta);
      chk("t4_err_cleared", 32'(bus.err), 32'd0);
      wait_start(2, ts);
      repeat (6) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("t4_done", 32'(bus.done), 32'd1);
      chk("t4_err", 32'(bus.err), 32'd2);
      chk("t4_rst_start", 32'({bus.core_rst, bus.core_start}), 32'b10);
      repeat (2) @(negedge clk);
      chk("t4_sid_left", 32'(exp_sid.size()), 32'd0);
      exp_start = '{4'b0100};
      exp_sid   = '{3'd4};
      send_cmd(5'b10000, ta);
      wait_done(200, td);
      chk("t4_next_err", 32'(bus.err), 32'd0);
      repeat (2) @(negedge clk);
      chk("t4_next_sid_left", 32'(exp_sid.size()), 32'd0);

      // T5: empty mask, then a stray finish during START
      nd = n_start;
      send_cmd(5'h00, ta);
      wait_done(20, td);
      chk("t5_latency", 32'(td - ta), 32'd2);
      chk("t5_err", 32'(bus.err), 32'd0);
      chk("t5_no_start", 32'(n_start - nd), 32'd0);
      inj       = 1'b1;
      exp_start = '{4'b0000};
      exp_sid   = '{3'd0};
      send_cmd(5'h01, ta);
      wait_done(200, td);
      inj = 1'b0;
      chk("t5_finish_ignored", 32'(t_sdone - t_start), 32'(L + 1));

      // T6: reset during stage-3 WAIT
      exp_start = '{4'b0000, 4'b0011, 4'b1000, 4'b1100};
      exp_sid   = '{3'd0, 3'd1, 3'd2};
      send_cmd(5'h1F, ta);
      wait_start(4, ts);
      repeat (3) @(negedge clk);
      nd  = n_done;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_reset_outputs", 32'(out_vec()), 32'h2000);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_ready", 32'(bus.cmd_ready), 32'd1);
      repeat (30) @(negedge clk);
      chk("t6_no_done", 32'(n_done - nd), 32'd0);
      chk("t6_idle", 32'({bus.busy, bus.core_rst}), 32'b01);
      chk("t6_start_left", 32'(exp_start.size()), 32'd0);
      chk("t6_sid_left", 32'(exp_sid.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
